// File: rtl/ntt_sequencer.sv
// ntt_sequencer
//   Address and control sequencer for a 256-point NTT engine with a single
//   butterfly unit. It issues one coefficient pair per cycle. Each layer has
//   128 issues, followed by a drain gap that lets the butterfly pipeline
//   empty before the next layer reads. Write-back addresses are the read
//   addresses delayed by D = RD_LAT + BF_LAT cycles.
//
// Ports
//   i_clk                      sole clock, rising edge
//   i_rst                      synchronous active-high reset
//   i_start, i_mode[1:0]       run request (sampled only in IDLE);
//                              00 fwd CT, 01 inv GS, 10 PWM, 11 reserved
//   o_busy, o_done             status: non-IDLE / one-cycle completion pulse
//   o_rd_en                    one butterfly issued per high cycle
//   o_rd_addr_a/b[7:0]         coefficient pair addresses
//   o_tw_addr[6:0]             twiddle ROM index
//   o_bf_ct, o_bf_pwm          butterfly mode controls latched at start
//   o_wr_en, o_wr_addr_a/b     write-back strobe and E/O destinations
module ntt_sequencer #(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_mode,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_rd_en,
    output logic [7:0] o_rd_addr_a,
    output logic [7:0] o_rd_addr_b,
    output logic [6:0] o_tw_addr,
    output logic       o_bf_ct,
    output logic       o_bf_pwm,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr_a,
    output logic [7:0] o_wr_addr_b
);
    localparam int D  = RD_LAT + BF_LAT;
    localparam int DW = (D > 1) ? $clog2(D) : 1;

    localparam logic [1:0] MODE_FWD = 2'b00;
    localparam logic [1:0] MODE_INV = 2'b01;
    localparam logic [1:0] MODE_PWM = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    r_mode;
    logic [2:0]    r_layer;
    logic [6:0]    r_idx;        // issue index within the current layer
    logic [7:0]    r_len;        // butterfly span (1 for PWM)
    logic [DW-1:0] r_drain_cnt;
    logic [7:0]    r_rd_a;
    logic [7:0]    r_rd_b;
    logic [6:0]    r_tw;
    logic          r_bf_ct;
    logic          r_bf_pwm;
    logic [D-1:0]  r_wr_en_pipe;
    logic [7:0]    r_wr_a_pipe [D];
    logic [7:0]    r_wr_b_pipe [D];

    logic       w_accept;
    logic       w_layer_end;
    logic       w_group_end;
    logic       w_drain_end;
    logic       w_last_layer;
    logic [7:0] w_mask;
    logic [6:0] w_idx_next;
    logic [7:0] w_len_next;
    logic [7:0] w_a_next;

    // Index i within a layer splits into a group number (high bits) and an
    // offset (low bits below len). Groups are 2*len apart, so the group bits
    // shift up by one while the offset passes through unchanged.
    function automatic logic [7:0] pair_addr_a(input logic [6:0] idx, input logic [7:0] len);
        logic [7:0] mask;
        logic [7:0] idx8;
        mask = len - 8'd1;
        idx8 = {1'b0, idx};
        return ((idx8 & ~mask) << 1) | (idx8 & mask);
    endfunction

    assign w_accept     = (r_state == S_IDLE) && i_start && (i_mode != MODE_RSV);
    assign w_mask       = r_len - 8'd1;
    assign w_layer_end  = (r_idx == 7'd127);
    assign w_group_end  = (({1'b0, r_idx} & w_mask) == w_mask);
    assign w_drain_end  = (r_drain_cnt == DW'(D - 1));
    assign w_last_layer = (r_mode == MODE_PWM) || (r_layer == 3'd6);
    assign w_idx_next   = r_idx + 7'd1;
    assign w_len_next   = (r_mode == MODE_FWD) ? (r_len >> 1) : (r_len << 1);
    assign w_a_next     = pair_addr_a(w_idx_next, r_len);

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
            S_ISSUE: if (w_layer_end) w_state_next = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_state_next = w_last_layer ? S_DONE : S_ISSUE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode      <= 2'b00;
            r_layer     <= 3'd0;
            r_idx       <= 7'd0;
            r_len       <= 8'd0;
            r_drain_cnt <= '0;
            r_rd_a      <= 8'd0;
            r_rd_b      <= 8'd0;
            r_tw        <= 7'd0;
            r_bf_ct     <= 1'b0;
            r_bf_pwm    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode   <= i_mode;
                        r_layer  <= 3'd0;
                        r_idx    <= 7'd0;
                        r_rd_a   <= 8'd0;
                        r_bf_ct  <= (i_mode != MODE_INV);
                        r_bf_pwm <= (i_mode == MODE_PWM);
                        case (i_mode)
                            MODE_INV: begin r_len <= 8'd2;   r_rd_b <= 8'd2;   r_tw <= 7'd127; end
                            MODE_PWM: begin r_len <= 8'd1;   r_rd_b <= 8'd1;   r_tw <= 7'd64;  end
                            default:  begin r_len <= 8'd128; r_rd_b <= 8'd128; r_tw <= 7'd1;   end
                        endcase
                    end
                end
                S_ISSUE: begin
                    // The last issue of a layer leaves the addresses holding
                    // their final values through the drain gap.
                    if (w_layer_end) begin
                        r_drain_cnt <= '0;
                    end else begin
                        r_idx  <= w_idx_next;
                        r_rd_a <= w_a_next;
                        r_rd_b <= w_a_next + r_len;
                        if (r_mode == MODE_PWM)
                            r_tw <= 7'd64 + (w_idx_next >> 1);
                        else if (w_group_end)
                            r_tw <= (r_mode == MODE_FWD) ? r_tw + 7'd1 : r_tw - 7'd1;
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + DW'(1);
                    // The step into the first group of the next layer is
                    // deferred to here so the twiddle index holds during drain.
                    if (w_drain_end && !w_last_layer) begin
                        r_layer <= r_layer + 3'd1;
                        r_idx   <= 7'd0;
                        r_len   <= w_len_next;
                        r_rd_a  <= 8'd0;
                        r_rd_b  <= w_len_next;
                        r_tw    <= (r_mode == MODE_FWD) ? r_tw + 7'd1 : r_tw - 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-back delay line. Stage k carries the issue from k+1 cycles ago.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the delay line is reset so that an aborted run leaves no stray write strobes behind.
            r_wr_en_pipe <= '0;
            for (int k = 0; k < D; k++) begin
                r_wr_a_pipe[k] <= 8'd0;
                r_wr_b_pipe[k] <= 8'd0;
            end
        end else begin
            r_wr_en_pipe[0] <= o_rd_en;
            r_wr_a_pipe[0]  <= r_rd_a;
            r_wr_b_pipe[0]  <= r_rd_b;
            for (int k = 1; k < D; k++) begin
                r_wr_en_pipe[k] <= r_wr_en_pipe[k-1];
                r_wr_a_pipe[k]  <= r_wr_a_pipe[k-1];
                r_wr_b_pipe[k]  <= r_wr_b_pipe[k-1];
            end
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_rd_en     = (r_state == S_ISSUE);
    assign o_rd_addr_a = r_rd_a;
    assign o_rd_addr_b = r_rd_b;
    assign o_tw_addr   = r_tw;
    assign o_bf_ct     = r_bf_ct;
    assign o_bf_pwm    = r_bf_pwm;
    assign o_wr_en     = r_wr_en_pipe[D-1];
    assign o_wr_addr_a = r_wr_a_pipe[D-1];
    assign o_wr_addr_b = r_wr_b_pipe[D-1];

endmodule

// File: tb/tb_ntt_sequencer.sv
// Self-checking bench for ntt_sequencer. A reference model expands each run
// into the expected issue and write-back sequences, including the cycle each
// one should appear. Each sampled cycle is compared against the heads of
// those queues.
module tb_ntt_sequencer;
    localparam int RD_LAT = 1;
    localparam int BF_LAT = 4;
    localparam int D      = RD_LAT + BF_LAT;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       busy, done, rd_en, bf_ct, bf_pwm, wr_en;
    logic [7:0] rd_a, rd_b, wr_a, wr_b;
    logic [6:0] tw;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
        int tw;
        int cyc;
    } op_t;

    op_t rd_q[$];
    op_t wr_q[$];

    ntt_sequencer #(.RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_mode      (mode),
        .o_busy      (busy),
        .o_done      (done),
        .o_rd_en     (rd_en),
        .o_rd_addr_a (rd_a),
        .o_rd_addr_b (rd_b),
        .o_tw_addr   (tw),
        .o_bf_ct     (bf_ct),
        .o_bf_pwm    (bf_pwm),
        .o_wr_en     (wr_en),
        .o_wr_addr_a (wr_a),
        .o_wr_addr_b (wr_b)
    );

    always #5 clk = ~clk;

    task automatic push_op(input int a, input int b, input int t, input int c);
        op_t op;
        op.a = a; op.b = b; op.tw = t; op.cyc = c;
        rd_q.push_back(op);
        op.tw = 0; op.cyc = c + D;
        wr_q.push_back(op);
    endtask

    // Expected sequence for a run whose start is sampled at the end of cycle 0.
    task automatic build_expected(input logic [1:0] m, output int exp_done, output int n_ops);
        int t, len, k, nl;
        rd_q.delete();
        wr_q.delete();
        if (m == 2'b10) begin
            nl = 1;
            for (int i = 0; i < 128; i++) push_op(2 * i, 2 * i + 1, 64 + (i >> 1), 1 + i);
        end else begin
            nl = 7;
            t  = (m == 2'b00) ? 1 : 127;
            for (int l = 0; l < 7; l++) begin
                len = (m == 2'b00) ? (128 >> l) : (2 << l);
                k   = 0;
                for (int s = 0; s < 256; s += 2 * len) begin
                    for (int j = s; j < s + len; j++) begin
                        push_op(j, j + len, t, 1 + l * (128 + D) + k);
                        k++;
                    end
                    t = (m == 2'b00) ? t + 1 : t - 1;
                end
            end
        end
        n_ops    = rd_q.size();
        exp_done = 1 + nl * (128 + D);
    endtask

    // Runs one operation to completion, comparing every cycle. A start with
    // mode 10 is pulsed at cycle pulse_cyc (if >0) and must be ignored.
    task automatic run_op(input logic [1:0] m, input int pulse_cyc, input string name);
        int   exp_done, n_ops, n_rd, done_cnt, cyc;
        int   last_a, last_b, last_tw;
        bit   have_last, exp_rd, exp_wr;
        op_t  e;
        logic exp_ct, exp_pwm;
        build_expected(m, exp_done, n_ops);
        exp_ct    = (m != 2'b01);
        exp_pwm   = (m == 2'b10);
        n_rd      = 0;
        done_cnt  = 0;
        have_last = 0;
        last_a = 0; last_b = 0; last_tw = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        for (cyc = 1; cyc <= exp_done + 1; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            checks++;
            if (rd_en !== exp_rd) begin
                errors++;
                $display("FAIL %s rd_en cyc=%0d got=%b exp=%b", name, cyc, rd_en, exp_rd);
            end
            if (rd_en === 1'b1) n_rd++;
            if (exp_rd) begin
                e = rd_q.pop_front();
                if (rd_en === 1'b1) begin
                    checks++;
                    if (rd_a !== 8'(e.a) || rd_b !== 8'(e.b) || tw !== 7'(e.tw)) begin
                        errors++;
                        $display("FAIL %s issue cyc=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                                 name, cyc, rd_a, rd_b, tw, e.a, e.b, e.tw);
                    end
                end
                last_a = e.a; last_b = e.b; last_tw = e.tw; have_last = 1;
            end else if (have_last && busy === 1'b1 && rd_en !== 1'b1) begin
                checks++;
                if (rd_a !== 8'(last_a) || rd_b !== 8'(last_b) || tw !== 7'(last_tw)) begin
                    errors++;
                    $display("FAIL %s hold cyc=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                             name, cyc, rd_a, rd_b, tw, last_a, last_b, last_tw);
                end
            end
            exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            checks++;
            if (wr_en !== exp_wr) begin
                errors++;
                $display("FAIL %s wr_en cyc=%0d got=%b exp=%b", name, cyc, wr_en, exp_wr);
            end
            if (exp_wr) begin
                e = wr_q.pop_front();
                if (wr_en === 1'b1) begin
                    checks++;
                    if (wr_a !== 8'(e.a) || wr_b !== 8'(e.b)) begin
                        errors++;
                        $display("FAIL %s write cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                                 name, cyc, wr_a, wr_b, e.a, e.b);
                    end
                end
            end
            checks++;
            if (busy !== (cyc <= exp_done) || done !== (cyc == exp_done)) begin
                errors++;
                $display("FAIL %s busy_done cyc=%0d got=%b/%b exp=%b/%b",
                         name, cyc, busy, done, (cyc <= exp_done), (cyc == exp_done));
            end
            if (done === 1'b1) done_cnt++;
            if (cyc <= exp_done) begin
                checks++;
                if (bf_ct !== exp_ct || bf_pwm !== exp_pwm) begin
                    errors++;
                    $display("FAIL %s bf_flags cyc=%0d got=%b/%b exp=%b/%b",
                             name, cyc, bf_ct, bf_pwm, exp_ct, exp_pwm);
                end
            end
            if (cyc == pulse_cyc) begin
                start = 1'b1;
                mode  = 2'b10;
            end
        end
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_after got busy=%b rd_en=%b wr_en=%b exp=0/0/0",
                         name, busy, rd_en, wr_en);
            end
        end
        checks++;
        if (done_cnt != 1 || n_rd != n_ops) begin
            errors++;
            $display("FAIL %s totals got done=%0d issues=%0d exp done=1 issues=%0d",
                     name, done_cnt, n_rd, n_ops);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({busy, done, rd_en, wr_en, bf_ct, bf_pwm} !== 6'b0 || rd_a !== 8'd0 ||
            rd_b !== 8'd0 || tw !== 7'd0 || wr_a !== 8'd0 || wr_b !== 8'd0) begin
            errors++;
            $display("FAIL %s flags=%b rd=(%0d,%0d,%0d) wr=(%0d,%0d) exp all 0",
                     name, {busy, done, rd_en, wr_en, bf_ct, bf_pwm}, rd_a, rd_b, tw, wr_a, wr_b);
        end
    endtask

    // Reset held together with start: reset must win and clear everything.
    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        mode  = 2'b00;
        repeat (2) @(negedge clk);
        check_all_zero("reset_with_start");
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_forward();
        run_op(2'b00, 0, "forward");
    endtask

    task automatic test_inverse();
        run_op(2'b01, 0, "inverse");
    endtask

    task automatic test_pwm();
        run_op(2'b10, 0, "pwm");
    endtask

    task automatic test_reserved_mode();
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b11;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reserved_mode got busy=%b rd_en=%b done=%b exp=0/0/0", busy, rd_en, done);
            end
            @(negedge clk);
        end
    endtask

    // PWM layer drains in cycles 129..133; a start at 130 lands mid-drain.
    task automatic test_start_during_drain();
        run_op(2'b10, 130, "start_in_drain");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b00;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset_mid_run");
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush got wr_en=%b busy=%b exp=0/0", wr_en, busy);
            end
        end
    endtask

    task automatic test_restart();
        run_op(2'b00, 0, "restart_forward");
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_pwm();
        test_reserved_mode();
        test_start_during_drain();
        test_reset_mid_run();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_sequencer.md
NTT_SEQUENCER -- requirements
Module: ntt_sequencer

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1, giving coefficient/twiddle RAM read latency in cycles.
REQ-002 The block SHALL have parameter BF_LAT, default 4, giving butterfly latency from operand valid to E/O valid in cycles.
REQ-003 The block SHALL use D = RD_LAT + BF_LAT as its issue-to-writeback delay.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request; sampled only in IDLE.
REQ-007 mode  input  2  00 forward NTT (CT), 01 inverse NTT (GS), 10 PWM, 11 reserved.
REQ-008 busy  output  1  high in every non-IDLE state.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 rd_en  output  1  operand-pair read strobe, one butterfly issued per high cycle.
REQ-011 rd_addr_a, rd_addr_b  output  8 each  coefficient addresses of the issued pair.
REQ-012 tw_addr  output  7  twiddle ROM index for the issued pair.
REQ-013 bf_ct, bf_pwm  output  1 each  butterfly mode controls, held constant from start acceptance to done.
REQ-014 wr_en  output  1  write-back strobe for E/O results.
REQ-015 wr_addr_a, wr_addr_b  output  8 each  destinations of E and O respectively.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ISSUE, DRAIN, DONE.
REQ-017 IDLE->ISSUE SHALL occur on start=1 with mode!=11; start with mode=11 SHALL be ignored.
REQ-018 Start acceptance SHALL latch mode and set bf_ct=1 for 00 and 10, bf_ct=0 for 01, and bf_pwm=1 only for 10.
REQ-019 In ISSUE, rd_en SHALL be 1 every cycle, issuing one butterfly per cycle for 128 cycles per layer.
REQ-020 Forward: layers l=0..6, len=128>>l; groups start at s=0,2len,...; pair j=s..s+len-1 issues a=j, b=j+len; tw starts at 1 and increments once per group (global across layers, ends at 127).
REQ-021 Inverse: layers l=0..6, len=2<<l; same a/b ordering; tw starts at 127 and decrements once per group (ends at 1).
REQ-022 PWM: a single layer of 128 issues; issue i drives a=2i, b=2i+1, tw=64+(i>>1).
REQ-023 After the last issue of a layer, ISSUE->DRAIN, with rd_en=0 for exactly D cycles.
REQ-024 DRAIN SHALL return to ISSUE for the next layer, or go to DONE after the final layer (layer 6, or the only PWM layer).
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE; busy SHALL deassert in that IDLE cycle.
REQ-026 wr_en/wr_addr_a/wr_addr_b SHALL equal rd_en/rd_addr_a/rd_addr_b delayed by exactly D cycles, using a D-deep shift register.
REQ-027 The last write of each layer SHALL therefore land in the final DRAIN cycle, and the next layer's first read follows one cycle later.
REQ-028 start while busy SHALL be ignored with no effect on counters or mode.
REQ-029 When rd_en=0, rd_addr_a, rd_addr_b and tw_addr SHALL hold their last values (don't-care to consumers).
REQ-030 Counters SHALL wrap only by explicit reload at layer and group boundaries; no address SHALL exceed 255 and no tw_addr SHALL exceed 127.

Reset
REQ-031 When rst=1, the FSM SHALL go to IDLE on the next edge with all outputs 0: busy, done, rd_en, wr_en, all addresses, tw_addr, bf_ct, bf_pwm.
REQ-032 rst mid-operation SHALL flush the write-delay pipeline so that no wr_en pulse follows reset.
REQ-033 rst SHALL have priority over start in the same cycle.

Verification
REQ-034 Forward NTT: start (mode=00) at cycle 0 -> cycle 1: a=0, b=128, tw=1; cycle 6: wr_en=1, wr_a=0, wr_b=128; cycle 134: a=0, b=64, tw=2; cycle 198: a=128, b=192, tw=3; done=1 at cycle 932 (D=5).
REQ-035 Inverse NTT: mode=01 -> issues (0,2,tw127), (1,3,127), (4,6,126); last issue of the run is (127,255,1); bf_ct=0 throughout; done at cycle 932.
REQ-036 PWM: mode=10 -> issues (0,1,64), (2,3,64), (4,5,65); bf_pwm=1; last issue (254,255,127) at cycle 128; done at cycle 134.
REQ-037 Boundaries: start with mode=11 -> busy stays 0; start pulsed during DRAIN -> no change and done count stays 1.
REQ-038 Reset mid-run: rst at cycle 50 of a forward NTT -> busy=0 and all outputs 0 by cycle 51; no wr_en afterwards; a new start runs identically to REQ-034.
